// File: rtl/change_dispenser_if.sv
// Request, hopper and inventory signals between the vending FSM / hopper
// and the change dispenser.
interface change_dispenser_if #(
   parameter int CNT_W = 4
);
   logic             req;
   logic [1:0]       change;
   logic             coin_ack;
   logic             load5;
   logic             load10;
   logic             busy;
   logic             eject5;
   logic             eject10;
   logic             done;
   logic             short;
   logic [1:0]       rem;
   logic [CNT_W-1:0] cnt5;
   logic [CNT_W-1:0] cnt10;
   logic             jam;

   modport master (
      output req, change, coin_ack, load5, load10,
      input  busy, eject5, eject10, done, short, rem, cnt5, cnt10, jam
   );

   modport slave (
      input  req, change, coin_ack, load5, load10,
      output busy, eject5, eject10, done, short, rem, cnt5, cnt10, jam
   );
endinterface

// File: rtl/change_dispenser.sv
// Two-tube coin payout: largest-coin-first dispensing with a 4-phase
// eject/ack handshake, inventory tracking, shortfall report and jam detect.
module change_dispenser #(
   parameter int N5_INIT  = 8,
   parameter int N10_INIT = 4,
   parameter int CNT_W    = 4,
   parameter int TIMEOUT  = 16
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SEL, EJECT, RELEASE, FIN, JAM} state_t;

   state_t        state_reg;
   logic [1:0]    r_reg;
   logic          coin10_reg;
   logic [TW-1:0] timer_reg;
   logic          busy_reg;
   logic          eject5_reg;
   logic          eject10_reg;
   logic          done_reg;
   logic          short_reg;
   logic [1:0]    rem_reg;
   logic          jam_reg;

   logic             dispense;
   logic [1:0]       load_vec;
   logic [1:0]       dec_vec;
   logic [CNT_W-1:0] cnt5_cur;
   logic [CNT_W-1:0] cnt10_cur;
   logic             pick10;
   logic             pick5;
   logic [1:0]       step;

   // Decrement happens on the edge that samples the ack in EJECT.
   assign dispense = (state_reg == EJECT) && bus.coin_ack;
   assign load_vec = {bus.load10, bus.load5};
   assign dec_vec  = {dispense & coin10_reg, dispense & ~coin10_reg};

   // Tube 0 holds 5-coins, tube 1 holds 10-coins.
   for (genvar gi = 0; gi < 2; gi++) begin : tube
      localparam logic [CNT_W-1:0] INIT_VAL =
         (gi == 0) ? CNT_W'(N5_INIT) : CNT_W'(N10_INIT);
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_reg <= INIT_VAL;
         end else if (load_vec[gi] && !dec_vec[gi]) begin
            if (cnt_reg != {CNT_W{1'b1}}) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else if (dec_vec[gi] && !load_vec[gi]) begin
            cnt_reg <= cnt_reg - 1'b1;
         end
      end
   end

   assign cnt5_cur  = tube[0].cnt_reg;
   assign cnt10_cur = tube[1].cnt_reg;

   assign pick10 = (r_reg >= 2'd2) && (cnt10_cur != '0);
   assign pick5  = !pick10 && (r_reg != 2'd0) && (cnt5_cur != '0);
   assign step   = coin10_reg ? 2'd2 : 2'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         r_reg       <= '0;
         coin10_reg  <= 1'b0;
         timer_reg   <= '0;
         busy_reg    <= 1'b0;
         eject5_reg  <= 1'b0;
         eject10_reg <= 1'b0;
         done_reg    <= 1'b0;
         short_reg   <= 1'b0;
         rem_reg     <= '0;
         jam_reg     <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         short_reg <= 1'b0;
         rem_reg   <= '0;
         case (state_reg)
            IDLE: begin
               if (bus.req) begin
                  if (bus.change != 2'd0) begin
                     r_reg     <= bus.change;
                     busy_reg  <= 1'b1;
                     state_reg <= SEL;
                  end else begin
                     r_reg     <= '0;
                     done_reg  <= 1'b1;
                     state_reg <= FIN;
                  end
               end
            end
            SEL: begin
               if (pick10 || pick5) begin
                  coin10_reg  <= pick10;
                  eject10_reg <= pick10;
                  eject5_reg  <= pick5;
                  timer_reg   <= '0;
                  state_reg   <= EJECT;
               end else begin
                  // Nothing left to pay, or no usable coin: report what remains.
                  done_reg  <= 1'b1;
                  rem_reg   <= r_reg;
                  short_reg <= (r_reg != 2'd0);
                  busy_reg  <= 1'b0;
                  state_reg <= FIN;
               end
            end
            EJECT: begin
               if (bus.coin_ack) begin
                  r_reg       <= r_reg - step;
                  eject5_reg  <= 1'b0;
                  eject10_reg <= 1'b0;
                  state_reg   <= RELEASE;
               end else if (timer_reg == TIMER_LAST) begin
                  eject5_reg  <= 1'b0;
                  eject10_reg <= 1'b0;
                  jam_reg     <= 1'b1;
                  state_reg   <= JAM;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            RELEASE: begin
               if (!bus.coin_ack) begin
                  state_reg <= SEL;
               end
            end
            FIN:     state_reg <= IDLE;
            JAM:     state_reg <= JAM;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.eject5  = eject5_reg;
   assign bus.eject10 = eject10_reg;
   assign bus.done    = done_reg;
   assign bus.short   = short_reg;
   assign bus.rem     = rem_reg;
   assign bus.cnt5    = cnt5_cur;
   assign bus.cnt10   = cnt10_cur;
   assign bus.jam     = jam_reg;
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins and completions are
// queued at request time and matched against what the hopper side observes.
module tb_change_dispenser;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 16;
   localparam int MAXC    = (1 << CNT_W) - 1;

   typedef struct {
      int short_v;
      int rem_v;
      int c5;
      int c10;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic l10 = 1'b0;
   logic hop_l10 = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   int   coin_q[$];
   exp_t done_q[$];
   int   m5 = 8;
   int   m10 = 4;
   bit   ack_en = 1'b1;
   bit   load_on_ack = 1'b0;

   always #5 clk = ~clk;

   change_dispenser_if #(.CNT_W(CNT_W)) bus ();

   assign bus.load10 = l10 | hop_l10;

   change_dispenser #(
      .N5_INIT (8),
      .N10_INIT(4),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Largest-coin-first payout against the bench's own inventory model.
   task automatic predict(input int ch);
      int r;
      bit paid10;
      r = ch;
      paid10 = 1'b0;
      forever begin
         if (r >= 2 && m10 > 0) begin
            coin_q.push_back(10);
            m10--;
            r -= 2;
            paid10 = 1'b1;
         end else if (r >= 1 && m5 > 0) begin
            coin_q.push_back(5);
            m5--;
            r -= 1;
         end else begin
            break;
         end
      end
      if (load_on_ack && paid10) m10++;
      done_q.push_back('{short_v: (r != 0), rem_v: r, c5: m5, c10: m10});
   endtask

   task automatic pulse_req(input int ch);
      bus.req    = 1'b1;
      bus.change = 2'(ch);
      tick();
      bus.req    = 1'b0;
      bus.change = 2'd0;
   endtask

   task automatic send_req(input int ch);
      predict(ch);
      pulse_req(ch);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_q.size() != 0 && k < 300) begin
         tick();
         k++;
      end
      chk("pending_done", done_q.size(), 0);
      chk("pending_coin", coin_q.size(), 0);
      tick();
   endtask

   task automatic run(input int ch);
      send_req(ch);
      wait_done();
   endtask

   // Hopper model: acks two cycles into an eject, releases once eject drops.
   initial begin
      int w;
      w = 0;
      bus.coin_ack = 1'b0;
      forever begin
         tick();
         hop_l10 = 1'b0;
         if (!rst) begin
            bus.coin_ack = 1'b0;
            w = 0;
         end else if ((bus.eject5 || bus.eject10) && !bus.coin_ack) begin
            if (ack_en) begin
               w++;
               if (w == 2) begin
                  bus.coin_ack = 1'b1;
                  w = 0;
                  if (load_on_ack && bus.eject10) begin
                     hop_l10 = 1'b1;
                     load_on_ack = 1'b0;
                  end
               end
            end
         end else if (bus.coin_ack && !bus.eject5 && !bus.eject10) begin
            bus.coin_ack = 1'b0;
         end
      end
   end

   initial begin
      logic p5, p10;
      int c;
      exp_t e;
      p5 = 1'b0;
      p10 = 1'b0;
      forever begin
         @(negedge clk);
         if ((bus.eject5 && !p5) || (bus.eject10 && !p10)) begin
            c = bus.eject10 ? 10 : 5;
            chk("eject_onehot", int'(bus.eject5 & bus.eject10), 0);
            if (coin_q.size() == 0) begin
               chk("unexpected_eject", c, 0);
            end else begin
               chk("coin", c, coin_q.pop_front());
               $display("eject coin %0d", c);
            end
         end
         p5  = bus.eject5;
         p10 = bus.eject10;
         if (bus.done) begin
            if (done_q.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = done_q.pop_front();
               chk("short", int'(bus.short), e.short_v);
               chk("rem", int'(bus.rem), e.rem_v);
               chk("cnt5", int'(bus.cnt5), e.c5);
               chk("cnt10", int'(bus.cnt10), e.c10);
               $display("done short=%0d rem=%0d cnt5=%0d cnt10=%0d",
                        bus.short, bus.rem, bus.cnt5, bus.cnt10);
            end
         end else begin
            chk("short_idle", int'(bus.short), 0);
            chk("rem_idle", int'(bus.rem), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.req = 1'b0;
      bus.change = 2'd0;
      bus.load5 = 1'b0;
      repeat (3) tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_jam", int'(bus.jam), 0);
      chk("rst_ej", int'(bus.eject5 | bus.eject10), 0);
      rst = 1'b1;
      tick();
      chk("init_cnt5", int'(bus.cnt5), 8);
      chk("init_cnt10", int'(bus.cnt10), 4);

      // 15 units: 10 then 5, with request-to-eject latency
      send_req(3);
      chk("sel_busy", int'(bus.busy), 1);
      chk("sel_no_eject", int'(bus.eject10), 0);
      tick();
      chk("eject_latency", int'(bus.eject10), 1);
      wait_done();

      // Refill coinciding with a 10-coin drop, plus a request while busy
      load_on_ack = 1'b1;
      send_req(2);
      repeat (3) tick();
      pulse_req(3);
      wait_done();
      repeat (20) tick();
      chk("cnt10_net", int'(bus.cnt10), m10);

      for (int i = 0; i < 3; i++) run(2);
      run(2);
      for (int i = 0; i < 4; i++) run(1);
      run(3);
      chk("shortfall_cnt5", int'(bus.cnt5), 0);

      // Zero change: completes without ever going busy
      send_req(0);
      for (int i = 0; i < 2; i++) begin
         chk("zero_busy", int'(bus.busy), 0);
         tick();
      end
      wait_done();

      run(3);

      bus.load5 = 1'b1;
      repeat (20) tick();
      bus.load5 = 1'b0;
      tick();
      m5 = (m5 + 20 > MAXC) ? MAXC : m5 + 20;
      chk("sat_cnt5", int'(bus.cnt5), m5);
      l10 = 1'b1;
      repeat (3) tick();
      l10 = 1'b0;
      tick();
      m10 = m10 + 3;
      chk("load_cnt10", int'(bus.cnt10), m10);

      // Jam: hopper never acks
      ack_en = 1'b0;
      coin_q.push_back(10);
      pulse_req(2);
      n = 0;
      while (!bus.eject10 && n < 10) begin
         tick();
         n++;
      end
      n = 0;
      while (bus.eject10 && n < 40) begin
         tick();
         n++;
      end
      chk("eject_hold", n, TIMEOUT);
      chk("jam", int'(bus.jam), 1);
      chk("jam_busy", int'(bus.busy), 1);
      chk("jam_ej", int'(bus.eject5 | bus.eject10), 0);
      chk("jam_cnt10", int'(bus.cnt10), m10);
      l10 = 1'b1;
      tick();
      l10 = 1'b0;
      tick();
      m10 = (m10 + 1 > MAXC) ? MAXC : m10 + 1;
      chk("jam_load", int'(bus.cnt10), m10);
      pulse_req(1);
      repeat (10) tick();
      chk("jam_sticky", int'(bus.jam), 1);

      #2 rst = 1'b0;
      #1;
      chk("arst_jam", int'(bus.jam), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_cnt5", int'(bus.cnt5), 8);
      chk("arst_cnt10", int'(bus.cnt10), 4);
      tick();
      rst = 1'b1;
      m5 = 8;
      m10 = 4;
      tick();

      // Reset while an eject is outstanding
      coin_q.push_back(5);
      pulse_req(1);
      tick();
      tick();
      chk("pre_rst_eject", int'(bus.eject5), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_eject", int'(bus.eject5), 0);
      chk("arst_busy2", int'(bus.busy), 0);
      tick();
      rst = 1'b1;
      ack_en = 1'b1;
      tick();

      run(3);
      repeat (10) tick();
      chk("final_coin_q", coin_q.size(), 0);
      chk("final_done_q", done_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
